freq_gate_ctrl: RTL and testbench

- Measurement sequencer for the 8-digit BCD frequency counter.
- Generates the counter clear pulse, the gate window and the result latch strobe.
- Hands each finished reading to the LCD controller through a req/ack handshake.
- Replaces the free-running one-second counter with selectable gate times, a clean stop between measurements, and overflow reporting.

---
 rtl/freq_pkg.sv | 29 ++
 rtl/gate_timer.sv | 26 ++
 rtl/freq_gate_ctrl.sv | 171 +++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared definitions for the frequency counter measurement sequencer.
// Gate selector encodings, sequencer states and the gate-length helper.
package freq_pkg;

    localparam int NDIGITS = 8;

    localparam logic [1:0] GATE_1S    = 2'b00;
    localparam logic [1:0] GATE_100MS = 2'b01;
    localparam logic [1:0] GATE_10MS  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_LATCH,
        ST_REQ
    } state_t;

    // Gate length in system clock cycles; the unused 2'b11 encoding falls back to 1 s.
    function automatic logic [31:0] gate_cycles(input int unsigned clk_hz, input logic [1:0] sel);
        case (sel)
            GATE_100MS: gate_cycles = clk_hz / 32'd10;
            GATE_10MS:  gate_cycles = clk_hz / 32'd100;
            default:    gate_cycles = clk_hz;
        endcase
    endfunction

endpackage

// File: rtl/gate_timer.sv
// gate_timer: loadable 32-bit down-counter with a zero flag.
// Load has priority over decrement; the count holds at zero.
module gate_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_dec,
    output logic        o_zero
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_zero = (r_count == 32'd0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer for the 8-digit BCD frequency counter.
// Drives counter clear, gate window and latch strobe, then offers each result to the LCD.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned ACK_TIMEOUT = 1000000
) (
    input  logic        CLOCK2_50,
    input  logic        RST_N,
    input  logic        run,
    input  logic [1:0]  gate_sel,
    input  logic        cnt_ovf,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        latch_en,
    output logic [1:0]  result_range,
    output logic        result_ovf,
    output logic        disp_req,
    input  logic        disp_ack,
    output logic        disp_timeout,
    output logic [15:0] meas_cnt
);

    localparam logic [31:0] LEN_1S_M1    = gate_cycles(CLK_HZ, GATE_1S) - 32'd1;
    localparam logic [31:0] LEN_100MS_M1 = gate_cycles(CLK_HZ, GATE_100MS) - 32'd1;
    localparam logic [31:0] LEN_10MS_M1  = gate_cycles(CLK_HZ, GATE_10MS) - 32'd1;
    localparam logic [31:0] SETTLE_M1    = SETTLE_CYC - 32'd1;
    localparam logic [31:0] ACK_M1       = ACK_TIMEOUT - 32'd1;

    state_t      r_state;
    logic        r_cnt_clr;
    logic        r_cnt_en;
    logic        r_latch_en;
    logic [1:0]  r_result_range;
    logic        r_result_ovf;
    logic        r_disp_req;
    logic        r_disp_timeout;
    logic [15:0] r_meas_cnt;
    logic [1:0]  r_gate_len_sel;
    logic        r_ovf_seen;

    logic [31:0] w_sel_len_m1;
    logic        w_gate_load;
    logic [31:0] w_gate_val;
    logic        w_gate_dec;
    logic        w_gate_zero;
    logic        w_ack_load;
    logic        w_ack_dec;
    logic        w_ack_zero;

    always_comb begin
        w_sel_len_m1 = LEN_1S_M1;
        case (gate_sel)
            GATE_100MS: w_sel_len_m1 = LEN_100MS_M1;
            GATE_10MS:  w_sel_len_m1 = LEN_10MS_M1;
            default:    w_sel_len_m1 = LEN_1S_M1;
        endcase
    end

    // One timer covers both the gate window and the settle delay that follows it.
    assign w_gate_load = (r_state == ST_CLEAR) || ((r_state == ST_GATE) && run && w_gate_zero);
    assign w_gate_val  = (r_state == ST_CLEAR) ? w_sel_len_m1 : SETTLE_M1;
    assign w_gate_dec  = (r_state == ST_GATE) || (r_state == ST_SETTLE);
    assign w_ack_load  = (r_state == ST_LATCH);
    assign w_ack_dec   = (r_state == ST_REQ);

    gate_timer u_gate_timer (
        .clk        (CLOCK2_50),
        .rst_n      (RST_N),
        .i_load     (w_gate_load),
        .i_load_val (w_gate_val),
        .i_dec      (w_gate_dec),
        .o_zero     (w_gate_zero)
    );

    gate_timer u_ack_timer (
        .clk        (CLOCK2_50),
        .rst_n      (RST_N),
        .i_load     (w_ack_load),
        .i_load_val (ACK_M1),
        .i_dec      (w_ack_dec),
        .o_zero     (w_ack_zero)
    );

    always_ff @(posedge CLOCK2_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ST_IDLE;
            r_cnt_clr      <= 1'b0;
            r_cnt_en       <= 1'b0;
            r_latch_en     <= 1'b0;
            r_result_range <= 2'b00;
            r_result_ovf   <= 1'b0;
            r_disp_req     <= 1'b0;
            r_disp_timeout <= 1'b0;
            r_meas_cnt     <= 16'd0;
            r_gate_len_sel <= 2'b00;
            r_ovf_seen     <= 1'b0;
        end else begin
            r_cnt_clr      <= 1'b0;
            r_latch_en     <= 1'b0;
            r_disp_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state   <= ST_CLEAR;
                        r_cnt_clr <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_gate_len_sel <= gate_sel;
                    r_ovf_seen     <= 1'b0;
                    r_cnt_en       <= 1'b1;
                    r_state        <= ST_GATE;
                end
                ST_GATE: begin
                    if (cnt_ovf) begin
                        r_ovf_seen <= 1'b1;
                    end
                    if (!run) begin
                        r_cnt_en  <= 1'b0;
                        r_cnt_clr <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_gate_zero) begin
                        r_cnt_en <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end
                end
                // Results are registered on entry to LATCH so they are valid alongside latch_en.
                ST_SETTLE: begin
                    if (cnt_ovf) begin
                        r_ovf_seen <= 1'b1;
                    end
                    if (w_gate_zero) begin
                        r_latch_en     <= 1'b1;
                        r_result_ovf   <= r_ovf_seen | cnt_ovf;
                        r_result_range <= r_gate_len_sel;
                        r_meas_cnt     <= r_meas_cnt + 16'd1;
                        r_state        <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_disp_req <= 1'b1;
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (disp_ack || w_ack_zero) begin
                        r_disp_req     <= 1'b0;
                        r_disp_timeout <= !disp_ack;
                        r_cnt_clr      <= run;
                        r_state        <= run ? ST_CLEAR : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_clr      = r_cnt_clr;
    assign cnt_en       = r_cnt_en;
    assign latch_en     = r_latch_en;
    assign result_range = r_result_range;
    assign result_ovf   = r_result_ovf;
    assign disp_req     = r_disp_req;
    assign disp_timeout = r_disp_timeout;
    assign meas_cnt     = r_meas_cnt;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: directed bench for the frequency counter measurement sequencer.
// Scaled parameters: 1000 Hz clock, 4 settle cycles, 20-cycle acknowledge timeout.
module tb_freq_gate_ctrl;

    localparam int LIMIT = 5000;

    logic        CLOCK2_50;
    logic        RST_N;
    logic        run;
    logic [1:0]  gate_sel;
    logic        cnt_ovf;
    logic        cnt_clr;
    logic        cnt_en;
    logic        latch_en;
    logic [1:0]  result_range;
    logic        result_ovf;
    logic        disp_req;
    logic        disp_ack;
    logic        disp_timeout;
    logic [15:0] meas_cnt;

    int testsRun;
    int testsFailed;

    int         mClrW, mEnW, mGap, mLatchW, mReqW;
    logic [1:0] mRange;
    logic       mOvf, mTimeout, mNextClr, mHung;
    int         mMeas;

    freq_gate_ctrl #(
        .CLK_HZ      (1000),
        .SETTLE_CYC  (4),
        .ACK_TIMEOUT (20)
    ) dut (
        .CLOCK2_50    (CLOCK2_50),
        .RST_N        (RST_N),
        .run          (run),
        .gate_sel     (gate_sel),
        .cnt_ovf      (cnt_ovf),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .latch_en     (latch_en),
        .result_range (result_range),
        .result_ovf   (result_ovf),
        .disp_req     (disp_req),
        .disp_ack     (disp_ack),
        .disp_timeout (disp_timeout),
        .meas_cnt     (meas_cnt)
    );

    initial CLOCK2_50 = 1'b0;
    always #5 CLOCK2_50 = ~CLOCK2_50;

    task automatic tick();
        @(negedge CLOCK2_50);
    endtask

    // Walks one full measurement from CLEAR to REQ exit, recording what each phase looked like.
    task automatic measure(input logic [1:0] sel, input int ackAt, input int ovfGateAt,
                           input int ovfSettleAt, input int toggleAt);
        int guard;
        guard = 0;
        mClrW = 0; mEnW = 0; mGap = 0; mLatchW = 0; mReqW = 0;
        mRange = 2'b11; mOvf = 1'bx; mMeas = -1;
        gate_sel = sel;
        while (cnt_clr !== 1'b1 && guard < LIMIT) begin tick(); guard++; end
        while (cnt_clr === 1'b1 && guard < LIMIT) begin mClrW++; tick(); guard++; end
        while (cnt_en === 1'b1 && guard < LIMIT) begin
            mEnW++;
            cnt_ovf = (mEnW == ovfGateAt);
            if (mEnW == toggleAt) gate_sel = ~gate_sel;
            tick(); guard++;
        end
        cnt_ovf = 1'b0;
        while (cnt_en === 1'b0 && latch_en !== 1'b1 && guard < LIMIT) begin
            mGap++;
            cnt_ovf = (mGap == ovfSettleAt);
            tick(); guard++;
        end
        cnt_ovf = 1'b0;
        while (latch_en === 1'b1 && guard < LIMIT) begin
            mLatchW++;
            mRange = result_range;
            mOvf   = result_ovf;
            mMeas  = int'(meas_cnt);
            tick(); guard++;
        end
        while (disp_req === 1'b1 && guard < LIMIT) begin
            mReqW++;
            disp_ack = (mReqW == ackAt);
            tick(); guard++;
        end
        disp_ack = 1'b0;
        mTimeout = disp_timeout;
        mNextClr = cnt_clr;
        mHung    = (guard >= LIMIT);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; run = 1'b0; gate_sel = 2'b00; cnt_ovf = 1'b0; disp_ack = 1'b0;
        tick(); tick();
        testsRun++; if ({cnt_clr, cnt_en, latch_en} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_ctrl_outs: got %b expected 000", {cnt_clr, cnt_en, latch_en}); end
        testsRun++; if ({result_range, result_ovf} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_result: got %b expected 000", {result_range, result_ovf}); end
        testsRun++; if ({disp_req, disp_timeout} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_disp: got %b expected 00", {disp_req, disp_timeout}); end
        testsRun++; if (meas_cnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_meas_cnt: got %0d expected 0", meas_cnt); end
        RST_N = 1'b1;
        tick(); tick(); tick();
        testsRun++; if ({cnt_clr, cnt_en} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle_stays: got %b expected 00", {cnt_clr, cnt_en}); end
    endtask

    task automatic test_basic();
        run = 1'b1; gate_sel = 2'b00;
        tick();
        testsRun++; if (cnt_clr !== 1'b1) begin testsFailed++; $display("[TB] FAIL start_latency_clr: got %b expected 1", cnt_clr); end
        measure(2'b00, 4, 0, 0, 0);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_bound: got %b expected 0", mHung); end
        testsRun++; if (mClrW != 1) begin testsFailed++; $display("[TB] FAIL basic_clr_width: got %0d expected 1", mClrW); end
        testsRun++; if (mEnW != 1000) begin testsFailed++; $display("[TB] FAIL basic_en_width: got %0d expected 1000", mEnW); end
        testsRun++; if (mGap != 4) begin testsFailed++; $display("[TB] FAIL basic_settle: got %0d expected 4", mGap); end
        testsRun++; if (mLatchW != 1) begin testsFailed++; $display("[TB] FAIL basic_latch_width: got %0d expected 1", mLatchW); end
        testsRun++; if (mRange !== 2'b00) begin testsFailed++; $display("[TB] FAIL basic_range: got %b expected 00", mRange); end
        testsRun++; if (mOvf !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_ovf: got %b expected 0", mOvf); end
        testsRun++; if (mMeas != 1) begin testsFailed++; $display("[TB] FAIL basic_meas_cnt: got %0d expected 1", mMeas); end
        testsRun++; if (mReqW != 4) begin testsFailed++; $display("[TB] FAIL basic_req_width: got %0d expected 4", mReqW); end
        testsRun++; if (mTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_timeout: got %b expected 0", mTimeout); end
        testsRun++; if (mNextClr !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_next_clear: got %b expected 1", mNextClr); end
    endtask

    task automatic test_gate_lengths();
        measure(2'b01, 2, 0, 0, 0);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL len100_bound: got %b expected 0", mHung); end
        testsRun++; if (mEnW != 100) begin testsFailed++; $display("[TB] FAIL len100_en_width: got %0d expected 100", mEnW); end
        testsRun++; if (mRange !== 2'b01) begin testsFailed++; $display("[TB] FAIL len100_range: got %b expected 01", mRange); end
        testsRun++; if (mMeas != 2) begin testsFailed++; $display("[TB] FAIL len100_meas_cnt: got %0d expected 2", mMeas); end
        measure(2'b10, 2, 0, 0, 5);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL len10_bound: got %b expected 0", mHung); end
        testsRun++; if (mEnW != 10) begin testsFailed++; $display("[TB] FAIL len10_toggle_en_width: got %0d expected 10", mEnW); end
        testsRun++; if (mRange !== 2'b10) begin testsFailed++; $display("[TB] FAIL len10_toggle_range: got %b expected 10", mRange); end
        testsRun++; if (mMeas != 3) begin testsFailed++; $display("[TB] FAIL len10_meas_cnt: got %0d expected 3", mMeas); end
    endtask

    task automatic test_overflow();
        measure(2'b00, 2, 500, 0, 0);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_gate_bound: got %b expected 0", mHung); end
        testsRun++; if (mOvf !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_gate_cycle500: got %b expected 1", mOvf); end
        testsRun++; if (mMeas != 4) begin testsFailed++; $display("[TB] FAIL ovf_gate_meas_cnt: got %0d expected 4", mMeas); end
        measure(2'b01, 2, 0, 0, 0);
        testsRun++; if (mOvf !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_cleared_next: got %b expected 0", mOvf); end
        measure(2'b10, 2, 0, 2, 0);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_settle_bound: got %b expected 0", mHung); end
        testsRun++; if (mOvf !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_settle_cycle2: got %b expected 1", mOvf); end
        testsRun++; if (mMeas != 6) begin testsFailed++; $display("[TB] FAIL ovf_settle_meas_cnt: got %0d expected 6", mMeas); end
    endtask

    task automatic test_abort();
        int guard;
        int enW;
        int sawLatch;
        int sawActive;
        guard = 0; enW = 0; sawLatch = 0; sawActive = 0;
        gate_sel = 2'b00;
        while (cnt_en !== 1'b1 && guard < LIMIT) begin tick(); guard++; end
        while (cnt_en === 1'b1 && guard < LIMIT) begin
            enW++;
            if (enW == 300) run = 1'b0;
            tick(); guard++;
        end
        testsRun++; if (guard >= LIMIT) begin testsFailed++; $display("[TB] FAIL abort_bound: got %0d cycles expected below %0d", guard, LIMIT); end
        testsRun++; if (enW != 300) begin testsFailed++; $display("[TB] FAIL abort_en_width: got %0d expected 300", enW); end
        testsRun++; if (cnt_clr !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_clr_pulse: got %b expected 1", cnt_clr); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (latch_en === 1'b1) sawLatch++;
            if (cnt_en === 1'b1 || cnt_clr === 1'b1 || disp_req === 1'b1) sawActive++;
        end
        testsRun++; if (sawLatch != 0) begin testsFailed++; $display("[TB] FAIL abort_no_latch: got %0d expected 0", sawLatch); end
        testsRun++; if (sawActive != 0) begin testsFailed++; $display("[TB] FAIL abort_idle: got %0d active cycles expected 0", sawActive); end
        testsRun++; if (meas_cnt !== 16'd6) begin testsFailed++; $display("[TB] FAIL abort_meas_cnt: got %0d expected 6", meas_cnt); end
    endtask

    task automatic test_timeout();
        run = 1'b1;
        measure(2'b10, 0, 0, 0, 0);
        testsRun++; if (mHung !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_bound: got %b expected 0", mHung); end
        testsRun++; if (mReqW != 20) begin testsFailed++; $display("[TB] FAIL timeout_req_width: got %0d expected 20", mReqW); end
        testsRun++; if (mTimeout !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got %b expected 1", mTimeout); end
        testsRun++; if (mMeas != 7) begin testsFailed++; $display("[TB] FAIL timeout_meas_cnt: got %0d expected 7", mMeas); end
        measure(2'b10, 20, 0, 0, 0);
        testsRun++; if (mReqW != 20) begin testsFailed++; $display("[TB] FAIL tie_req_width: got %0d expected 20", mReqW); end
        testsRun++; if (mTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL tie_ack_wins: got %b expected 0", mTimeout); end
        testsRun++; if (mNextClr !== 1'b1) begin testsFailed++; $display("[TB] FAIL tie_next_clear: got %b expected 1", mNextClr); end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        gate_sel = 2'b10;
        while (cnt_en !== 1'b1 && guard < LIMIT) begin tick(); guard++; end
        cnt_ovf = 1'b1;
        tick();
        cnt_ovf = 1'b0;
        while (disp_req !== 1'b1 && guard < LIMIT) begin tick(); guard++; end
        tick();
        testsRun++; if (guard >= LIMIT) begin testsFailed++; $display("[TB] FAIL rst_bound: got %0d cycles expected below %0d", guard, LIMIT); end
        testsRun++; if ({disp_req, result_ovf} !== 2'b11) begin testsFailed++; $display("[TB] FAIL rst_pre_state: got %b expected 11", {disp_req, result_ovf}); end
        testsRun++; if (meas_cnt !== 16'd9) begin testsFailed++; $display("[TB] FAIL rst_pre_meas_cnt: got %0d expected 9", meas_cnt); end
        #2 RST_N = 1'b0;
        #1;
        testsRun++; if ({disp_req, result_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL rst_async_clear: got %b expected 00", {disp_req, result_ovf}); end
        testsRun++; if (meas_cnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL rst_async_meas_cnt: got %0d expected 0", meas_cnt); end
        tick(); tick();
        RST_N = 1'b1;
        tick();
        testsRun++; if (cnt_clr !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_release_clear: got %b expected 1", cnt_clr); end
        tick();
        testsRun++; if (cnt_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_release_gate: got %b expected 1", cnt_en); end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_basic();
        test_gate_lengths();
        test_overflow();
        test_abort();
        test_timeout();
        test_async_reset();
        run = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
